// File: rtl/adc_clk_pkg.sv
// Shared state encoding, output bundle and default timing constants for the
// ADC/PLL clock-and-reset supervisor.
package adc_clk_pkg;

  typedef enum logic [2:0] {
    RESET_PLL   = 3'd0,
    WAIT_LOCK   = 3'd1,
    STABLE      = 3'd2,
    RELEASE_SYS = 3'd3,
    RUN         = 3'd4,
    FAULT       = 3'd5
  } sup_state_t;

  typedef struct packed {
    logic pll_rst;
    logic sys_rst_n;
    logic adc_rst_n;
    logic ready;
    logic fault;
  } sup_out_t;

  localparam int unsigned DEF_PLL_RST_CYCLES     = 32;
  localparam int unsigned DEF_LOCK_TIMEOUT       = 50000;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1000;
  localparam int unsigned DEF_STAGGER_CYCLES     = 16;
  localparam int unsigned DEF_MAX_RETRIES        = 3;

  function automatic int unsigned at_least_one(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Output levels are a pure function of the state being entered, so they can
  // be registered on the same edge as the transition itself.
  function automatic sup_out_t out_of(input sup_state_t s);
    sup_out_t o;
    o.pll_rst   = (s == RESET_PLL) || (s == FAULT);
    o.sys_rst_n = (s == RELEASE_SYS) || (s == RUN);
    o.adc_rst_n = (s == RUN);
    o.ready     = (s == RUN);
    o.fault     = (s == FAULT);
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the refclk domain.
module sync_2ff (
  input  logic refclk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/adc_pll_supervisor.sv
// Sequences PLL reset, lock qualification and staggered release of the system
// and ADC reset domains; retries lock timeouts and latches FAULT when exhausted.
module adc_pll_supervisor
  import adc_clk_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned STAGGER_CYCLES     = DEF_STAGGER_CYCLES,
  parameter int unsigned MAX_RETRIES        = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       clr_fault,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       adc_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [7:0] relock_count,
  output logic [2:0] state
);

  localparam int unsigned RST_N   = at_least_one(PLL_RST_CYCLES);
  localparam int unsigned TO_N    = at_least_one(LOCK_TIMEOUT);
  localparam int unsigned STB_N   = at_least_one(LOCK_STABLE_CYCLES);
  localparam int unsigned STG_N   = at_least_one(STAGGER_CYCLES);
  localparam int unsigned RETRY_N = at_least_one(MAX_RETRIES);

  localparam int unsigned CNT_MAX = max_u(max_u(RST_N, TO_N), max_u(STB_N, STG_N));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned RETRY_W = $clog2(RETRY_N + 1);

  localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_N - 1);
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TO_N - 1);
  localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(STB_N - 1);
  localparam logic [CNT_W-1:0]   STG_LAST  = CNT_W'(STG_N - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_N);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic               locked_s;
  sup_state_t         cur;
  sup_out_t           outs;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retries;

  sync_2ff u_lock_sync (
    .refclk (refclk),
    .rst_n  (rst_n),
    .d      (pll_locked),
    .q      (locked_s)
  );

  // Every transition writes state, outputs and a cleared counter together.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cur          <= RESET_PLL;
      outs         <= out_of(RESET_PLL);
      cnt          <= '0;
      retries      <= '0;
      relock_count <= 8'd0;
    end else begin
      cnt <= cnt + CNT_W'(1);
      unique case (cur)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            cur  <= WAIT_LOCK;
            outs <= out_of(WAIT_LOCK);
            cnt  <= '0;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            cur  <= STABLE;
            outs <= out_of(STABLE);
            cnt  <= '0;
          end else if (cnt == TO_LAST) begin
            cnt <= '0;
            if (retries == RETRY_LIM) begin
              cur  <= FAULT;
              outs <= out_of(FAULT);
            end else begin
              retries <= retries + RETRY_W'(1);
              cur     <= RESET_PLL;
              outs    <= out_of(RESET_PLL);
            end
          end
        end
        STABLE: begin
          // A single unlocked sample restarts qualification without charging a retry.
          if (!locked_s) begin
            cur  <= WAIT_LOCK;
            outs <= out_of(WAIT_LOCK);
            cnt  <= '0;
          end else if (cnt == STB_LAST) begin
            retries <= '0;
            cur     <= RELEASE_SYS;
            outs    <= out_of(RELEASE_SYS);
            cnt     <= '0;
          end
        end
        RELEASE_SYS: begin
          if (!locked_s) begin
            cur  <= RESET_PLL;
            outs <= out_of(RESET_PLL);
            cnt  <= '0;
          end else if (cnt == STG_LAST) begin
            cur  <= RUN;
            outs <= out_of(RUN);
            cnt  <= '0;
          end
        end
        RUN: begin
          cnt <= '0;
          if (!locked_s) begin
            relock_count <= sat_inc8(relock_count);
            cur          <= RESET_PLL;
            outs         <= out_of(RESET_PLL);
          end
        end
        FAULT: begin
          cnt <= '0;
          if (clr_fault) begin
            retries <= '0;
            cur     <= RESET_PLL;
            outs    <= out_of(RESET_PLL);
          end
        end
        default: begin
          cur  <= RESET_PLL;
          outs <= out_of(RESET_PLL);
          cnt  <= '0;
        end
      endcase
    end
  end

  assign pll_rst   = outs.pll_rst;
  assign sys_rst_n = outs.sys_rst_n;
  assign adc_rst_n = outs.adc_rst_n;
  assign ready     = outs.ready;
  assign fault     = outs.fault;
  assign state     = cur;

endmodule

// File: tb/tb_adc_pll_supervisor.sv
// Directed sequences with randomized dwell times; expected timings come from
// edge arithmetic on the sequencing rules (sync delay, pulse, stable, stagger).
module tb_adc_pll_supervisor;

  localparam int PLL = 4;
  localparam int TO  = 100;
  localparam int LS  = 10;
  localparam int ST  = 3;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       clr_fault;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       adc_rst_n;
  logic       ready;
  logic       fault;
  logic [7:0] relock_count;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int relocks = 0;

  adc_pll_supervisor #(
    .PLL_RST_CYCLES     (PLL),
    .LOCK_TIMEOUT       (TO),
    .LOCK_STABLE_CYCLES (LS),
    .STAGGER_CYCLES     (ST),
    .MAX_RETRIES        (2)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .clr_fault    (clr_fault),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .adc_rst_n    (adc_rst_n),
    .ready        (ready),
    .fault        (fault),
    .relock_count (relock_count),
    .state        (state)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_pll_rst"}, pll_rst, 1);
    chk({tag, "_sys_rst_n"}, sys_rst_n, 0);
    chk({tag, "_adc_rst_n"}, adc_rst_n, 0);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_relock"}, relock_count, 0);
  endtask

  task automatic measure_pll_high(output int n);
    n = 0;
    while (pll_rst === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
  endtask

  // Optionally pulses clr_fault part-way through, which must have no effect.
  task automatic measure_pll_low(output int n, input bit poke);
    n = 0;
    while (pll_rst === 1'b0 && n < 1000) begin
      clr_fault = poke && (n == 10);
      n++;
      tick();
    end
    clr_fault = 1'b0;
  endtask

  task automatic wait_release(output int sys_at, output int rdy_at);
    sys_at = -1;
    rdy_at = -1;
    for (int i = 0; i < 1000 && rdy_at < 0; i++) begin
      tick();
      if (sys_rst_n === 1'b1 && sys_at < 0) begin
        sys_at = cyc;
        chk("adc_held_at_sys_release", adc_rst_n, 0);
      end
      if (ready === 1'b1) rdy_at = cyc;
    end
    chk("adc_at_ready", adc_rst_n, 1);
  endtask

  // One-cycle lock loss in RUN, then the whole re-sequence.
  task automatic relock_cycle();
    int n, w, sys_at, rdy_at;
    repeat ($urandom_range(1, 6)) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    chk("drop_hold1", ready, 1);
    tick();
    chk("drop_hold2", ready, 1);
    tick();
    relocks = (relocks < 255) ? relocks + 1 : 255;
    chk("drop_ready", ready, 0);
    chk("drop_sys", sys_rst_n, 0);
    chk("drop_adc", adc_rst_n, 0);
    chk("drop_pll", pll_rst, 1);
    chk("drop_state", state, 0);
    chk("relock_count", relock_count, relocks);
    measure_pll_high(n);
    chk("relock_pulse", n, PLL);
    w = cyc;
    wait_release(sys_at, rdy_at);
    chk("relock_sys", sys_at, w + 1 + LS);
    chk("relock_ready", rdy_at, w + 1 + LS + ST);
  endtask

  task automatic run_to_fault(input bit poke);
    int n;
    for (int i = 0; i < 3; i++) begin
      measure_pll_high(n);
      chk("retry_pulse", n, PLL);
      measure_pll_low(n, poke && (i == 0));
      chk("timeout_len", n, TO);
    end
    chk("fault_state", state, 5);
    chk("fault_flag", fault, 1);
    chk("fault_pll", pll_rst, 1);
    chk("fault_sys", sys_rst_n, 0);
    chk("fault_adc", adc_rst_n, 0);
    chk("fault_ready", ready, 0);
  endtask

  initial begin
    int n, w, k, r, sys_at, rdy_at;
    rst_n = 1'b0;
    pll_locked = 1'b0;
    clr_fault = 1'b0;
    tick();
    tick();
    reset_vals("reset");

    // Basic bring-up: lock arrives 20 cycles after pll_rst falls.
    rst_n = 1'b1;
    measure_pll_high(n);
    chk("pll_pulse", n, PLL);
    chk("wait_state", state, 1);
    chk("wait_sys", sys_rst_n, 0);
    w = cyc;
    repeat (19) tick();
    pll_locked = 1'b1;
    wait_release(sys_at, rdy_at);
    chk("bringup_sys", sys_at, w + 20 + 2 + LS);
    chk("bringup_ready", rdy_at, w + 20 + 2 + LS + ST);
    chk("stagger", rdy_at - sys_at, ST);
    chk("run_state", state, 4);

    // Lock losses in RUN, enough to saturate the counter.
    for (int i = 0; i < 256; i++) relock_cycle();
    chk("relock_saturated", relock_count, 255);

    // Asynchronous reset while in RUN.
    #3 rst_n = 1'b0;
    #1 reset_vals("rst_in_run");
    relocks = 0;
    tick();
    rst_n = 1'b1;
    measure_pll_high(n);
    chk("restart_pulse", n, PLL);
    w = cyc;
    wait_release(sys_at, rdy_at);
    chk("restart_ready", rdy_at, w + 1 + LS + ST);

    // Lock glitch while qualifying in STABLE at count 5.
    pll_locked = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    measure_pll_high(n);
    chk("glitch_pulse", n, PLL);
    repeat (19) tick();
    pll_locked = 1'b1;
    k = cyc;
    repeat (6) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    r = k + 8;
    tick();
    chk("glitch_still_stable", state, 2);
    tick();
    chk("glitch_wait", state, 1);
    chk("glitch_no_pll_rst", pll_rst, 0);
    tick();
    chk("glitch_restable", state, 2);
    wait_release(sys_at, rdy_at);
    chk("glitch_sys", sys_at, r + 2 + LS);
    chk("glitch_ready", rdy_at, r + 2 + LS + ST);

    // Lock never arrives: retries exhaust into FAULT, clear restarts with fresh retries.
    pll_locked = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run_to_fault(1'b1);
    repeat (5) tick();
    chk("fault_hold", state, 5);
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    chk("clr_state", state, 0);
    chk("clr_fault_low", fault, 0);
    chk("clr_pll", pll_rst, 1);
    run_to_fault(1'b0);

    // Asynchronous reset while in FAULT.
    #3 rst_n = 1'b0;
    #1 reset_vals("rst_in_fault");
    tick();
    rst_n = 1'b1;
    measure_pll_high(n);
    chk("post_fault_pulse", n, PLL);
    chk("post_fault_state", state, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_pll_supervisor.md
ADC_PLL_SUPERVISOR -- requirements
Module: adc_pll_supervisor

Interface
REQ-001 Parameter PLL_RST_CYCLES, default 32: refclk cycles pll_rst is held high per reset pulse.
REQ-002 Parameter LOCK_TIMEOUT, default 50000: refclk cycles allowed for lock after pll_rst release (1 ms at 50 MHz).
REQ-003 Parameter LOCK_STABLE_CYCLES, default 1000: consecutive locked cycles required before release.
REQ-004 Parameter STAGGER_CYCLES, default 16: cycles between sys_rst_n and adc_rst_n deassertion.
REQ-005 Parameter MAX_RETRIES, default 3: lock timeouts tolerated before FAULT.
REQ-006 refclk  in  1  free-running 50 MHz reference clock; all logic in this domain.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 pll_locked  in  1  PLL lock indicator, asynchronous to refclk.
REQ-009 clr_fault  in  1  single-cycle pulse, leaves FAULT.
REQ-010 pll_rst  out  1  active-high reset to the PLL.
REQ-011 sys_rst_n  out  1  active-low reset for 50/100/200 MHz logic.
REQ-012 adc_rst_n  out  1  active-low reset for ADC-clock logic.
REQ-013 ready  out  1  high only in RUN.
REQ-014 fault  out  1  high only in FAULT.
REQ-015 relock_count  out  8  saturating count of lock losses seen in RUN.
REQ-016 state  out  3  current FSM state encoding.

Function
REQ-017 pll_locked SHALL pass a 2-flop synchronizer; FSM uses only locked_s (2-cycle latency).
REQ-018 All outputs SHALL be registered; FSM transitions and outputs change on the same refclk edge.
REQ-019 States: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RELEASE_SYS=3, RUN=4, FAULT=5.
REQ-020 RESET_PLL: pll_rst=1, sys_rst_n=adc_rst_n=0; after PLL_RST_CYCLES cycles -> WAIT_LOCK, counter cleared.
REQ-021 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABLE; counter reaching LOCK_TIMEOUT -> retries+1 and RESET_PLL, or FAULT if retries already equals MAX_RETRIES.
REQ-022 STABLE: counts consecutive locked_s=1; locked_s=0 -> WAIT_LOCK with timeout counter cleared (no retry charged); count reaching LOCK_STABLE_CYCLES -> RELEASE_SYS, retries cleared.
REQ-023 RELEASE_SYS: sys_rst_n=1, adc_rst_n=0; after STAGGER_CYCLES -> RUN; locked_s=0 -> RESET_PLL with sys_rst_n=0 next cycle.
REQ-024 RUN: sys_rst_n=adc_rst_n=1, ready=1; locked_s=0 at cycle N -> at N+1 ready=0, both resets low, pll_rst=1, state RESET_PLL, relock_count+1 saturating at 255.
REQ-025 FAULT: pll_rst=1, both resets low, fault=1; clr_fault -> RESET_PLL with retries cleared; clr_fault ignored in other states.
REQ-026 Single shared counter, width ceil(log2(max parameter+1)), cleared on every state change.
REQ-027 Parameters of 0 SHALL be treated as 1.

Reset
REQ-028 rst_n low SHALL asynchronously force state=RESET_PLL, pll_rst=1, sys_rst_n=0, adc_rst_n=0, ready=0, fault=0, relock_count=0, retries=0, counter=0, synchronizer=0.
REQ-029 rst_n deassertion is synchronized externally; reset mid-operation (any state) returns to REQ-028 values immediately.

Structure
REQ-030 State encoding and default parameter constants SHALL live in shared package adc_clk_pkg.
REQ-031 Synchronizer SHALL be sub-module sync_2ff (1-bit, refclk, rst_n), reusable elsewhere.

Verification
REQ-032 Params 4/100/10/3/2; locked rises 20 cycles after pll_rst falls -> pll_rst high exactly 4 cycles, ready high 2+10+3 cycles after locked rises, adc_rst_n 3 cycles after sys_rst_n.
REQ-033 locked never rises -> three 100-cycle timeouts with 4-cycle pll_rst pulses, then FAULT, fault=1; clr_fault pulse -> RESET_PLL, fault=0.
REQ-034 In RUN, locked drops for 1 cycle -> ready=0 and both resets low 3 cycles later, relock_count=1, full re-sequence follows.
REQ-035 locked glitches low once during STABLE at count 5 -> STABLE restarts, ready delayed by the lost count, retries unchanged.
REQ-036 256 lock losses in RUN -> relock_count saturates at 255.
REQ-037 rst_n pulsed low in RUN and in FAULT -> all outputs at REQ-028 values within the same cycle, sequence restarts.
